// File: rtl/deserializer_pkg.sv
// rtl/deserializer_pkg.sv - shared types and constants for the serial deserializer
package deserializer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      STOP,
      BREAK
   } deser_state_e;

   localparam int DEF_PKT_W      = 4;
   localparam int DEF_FIFO_DEPTH = 2;

   // start bit + payload + stop bit
   function automatic int frame_len(input int pkt_w);
      return pkt_w + 2;
   endfunction

   localparam int DEF_FRAME_LEN = frame_len(DEF_PKT_W);

endpackage

// File: rtl/deser_fifo.sv
// rtl/deser_fifo.sv - output word buffer; a pop on a full buffer frees room for a same-cycle push
module deser_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/deserializer.sv
// rtl/deserializer.sv - start/stop framed serial receiver feeding a small word buffer
module deserializer
   import deserializer_pkg::*;
#(
   parameter int PKT_W      = DEF_PKT_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_sIn,
   output logic [PKT_W-1:0] io_pOut,
   output logic             io_validOut,
   input  logic             io_readyOut,
   output logic             io_frameErr,
   output logic             io_overrun,
   output logic             io_busy
);

   localparam int CNT_W    = $clog2(PKT_W + 1);
   localparam int LAST_BIT = frame_len(PKT_W) - 3;

   logic             rst_meta;
   logic             rst_n;
   deser_state_e     state;
   logic [CNT_W-1:0] bit_cnt;
   logic [PKT_W-1:0] shift_q;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;

   // reset asserts asynchronously, releases two clocks later
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   assign push        = (state == STOP) && io_sIn;
   assign pop         = io_validOut && io_readyOut;
   assign io_validOut = !fifo_empty;
   assign io_busy     = (state != IDLE);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shift_q     <= '0;
         io_frameErr <= 1'b0;
         io_overrun  <= 1'b0;
      end else begin
         io_frameErr <= 1'b0;
         io_overrun  <= push && fifo_full && !pop;
         case (state)
            IDLE: begin
               if (!io_sIn) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               for (int i = 0; i < PKT_W; i++) begin
                  if (bit_cnt == CNT_W'(i)) shift_q[i] <= io_sIn;
               end
               bit_cnt <= bit_cnt + CNT_W'(1);
               if (bit_cnt == CNT_W'(LAST_BIT)) state <= STOP;
            end
            STOP: begin
               if (io_sIn) begin
                  state <= IDLE;
               end else begin
                  io_frameErr <= 1'b1;
                  state       <= BREAK;
               end
            end
            BREAK: begin
               if (io_sIn) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   deser_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (shift_q),
      .pop       (pop),
      .head      (io_pOut),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - scoreboard bench for deserializer with directed and random frames
module tb_deserializer;
   import deserializer_pkg::*;

   localparam int PKT_W = DEF_PKT_W;
   localparam int DEPTH = DEF_FIFO_DEPTH;

   logic             clock       = 1'b0;
   logic             reset       = 1'b1;
   logic             io_sIn      = 1'b1;
   logic             io_readyOut = 1'b0;
   logic [PKT_W-1:0] io_pOut;
   logic             io_validOut;
   logic             io_frameErr;
   logic             io_overrun;
   logic             io_busy;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;
   int rdy_mode = 1;

   logic [PKT_W-1:0] mq[$];
   logic [PKT_W-1:0] exp_q[$];
   int               pop_cycles[$];

   logic exp_valid = 1'b0;
   logic exp_ovr   = 1'b0;
   logic exp_ferr  = 1'b0;
   logic exp_busy  = 1'b0;
   bit   mon_en    = 1'b0;

   logic             prev_hold = 1'b0;
   logic [PKT_W-1:0] prev_word = '0;

   deserializer #(
      .PKT_W      (PKT_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .io_sIn      (io_sIn),
      .io_pOut     (io_pOut),
      .io_validOut (io_validOut),
      .io_readyOut (io_readyOut),
      .io_frameErr (io_frameErr),
      .io_overrun  (io_overrun),
      .io_busy     (io_busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cycle++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
      end
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         check("valid", io_validOut, exp_valid);
         check("overrun", io_overrun, exp_ovr);
         check("frame_err", io_frameErr, exp_ferr);
         check("busy", io_busy, exp_busy);
         if (prev_hold) check("hold_word", io_pOut, prev_word);
         if (io_validOut && io_readyOut) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %0h expected none at cycle %0d", io_pOut, cycle);
            end else begin
               check("word", io_pOut, exp_q.pop_front());
            end
            pop_cycles.push_back(cycle);
         end
         prev_hold = io_validOut && !io_readyOut;
         prev_word = io_pOut;
      end else begin
         prev_hold = 1'b0;
      end
   end

   function automatic logic pick_rdy();
      if (rdy_mode == 0) return 1'b0;
      if (rdy_mode == 1) return 1'b1;
      return logic'($urandom_range(0, 1));
   endfunction

   // kind: 0 = ordinary bit, 1 = valid stop bit carrying word, 2 = stop bit sampled low
   task automatic tick(input logic sin, input logic rdy, input logic nbusy,
                       input int kind, input logic [PKT_W-1:0] word);
      logic n_ovr;
      logic n_ferr;
      n_ovr  = 1'b0;
      n_ferr = 1'b0;
      io_sIn      = sin;
      io_readyOut = rdy;
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (kind == 1) begin
         if (mq.size() < DEPTH) begin
            mq.push_back(word);
            exp_q.push_back(word);
         end else begin
            n_ovr = 1'b1;
         end
      end
      if (kind == 2) n_ferr = 1'b1;
      @(posedge clock);
      #1;
      exp_valid = (mq.size() > 0);
      exp_ovr   = n_ovr;
      exp_ferr  = n_ferr;
      exp_busy  = nbusy;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, pick_rdy(), 1'b0, 0, '0);
   endtask

   task automatic send_frame(input logic [PKT_W-1:0] word, input logic stop_bit, input int stop_rdy);
      logic r;
      tick(1'b0, pick_rdy(), 1'b1, 0, '0);
      for (int i = 0; i < PKT_W; i++) tick(word[i], pick_rdy(), 1'b1, 0, '0);
      r = (stop_rdy < 0) ? pick_rdy() : stop_rdy[0];
      tick(stop_bit, r, !stop_bit, stop_bit ? 1 : 2, word);
   endtask

   task automatic break_hold(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, pick_rdy(), 1'b1, 0, '0);
      tick(1'b1, pick_rdy(), 1'b0, 0, '0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_pout"}, io_pOut, '0);
      check({tag, "_valid"}, io_validOut, 1'b0);
      check({tag, "_ferr"}, io_frameErr, 1'b0);
      check({tag, "_ovr"}, io_overrun, 1'b0);
      check({tag, "_busy"}, io_busy, 1'b0);
   endtask

   initial begin
      int n;
      logic [PKT_W-1:0] w;
      logic [PKT_W-1:0] partial;

      #1 reset = 1'b0;
      #2 check_zero_outputs("reset");
      @(posedge clock);
      #1 reset = 1'b1;
      mon_en = 1'b1;
      idle(3);

      rdy_mode = 1;
      send_frame(4'hA, 1'b1, -1);
      idle(2);

      send_frame(4'hA, 1'b1, -1);
      send_frame(4'hF, 1'b1, -1);
      idle(2);
      n = pop_cycles.size();
      check("b2b_gap", (n >= 2) ? pop_cycles[n-1] - pop_cycles[n-2] : -1, DEF_FRAME_LEN);

      send_frame(4'h5, 1'b0, -1);
      break_hold(3);
      idle(1);

      rdy_mode = 0;
      send_frame(4'h1, 1'b1, -1);
      send_frame(4'h2, 1'b1, -1);
      send_frame(4'h3, 1'b1, -1);
      idle(2);
      rdy_mode = 1;
      idle(4);

      rdy_mode = 0;
      send_frame(4'h1, 1'b1, -1);
      send_frame(4'h2, 1'b1, -1);
      send_frame(4'h3, 1'b1, 1);
      idle(1);
      rdy_mode = 1;
      idle(5);

      rdy_mode = 0;
      send_frame(4'h9, 1'b1, -1);
      partial = 4'h6;
      tick(1'b0, 1'b0, 1'b1, 0, '0);
      tick(partial[0], 1'b0, 1'b1, 0, '0);
      tick(partial[1], 1'b0, 1'b1, 0, '0);
      mon_en = 1'b0;
      reset  = 1'b0;
      io_sIn = 1'b1;
      #1 check_zero_outputs("mid_reset");
      mq.delete();
      exp_q.delete();
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      exp_ferr  = 1'b0;
      exp_busy  = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1 check_zero_outputs("held_reset");
      reset  = 1'b1;
      mon_en = 1'b1;
      idle(3);
      rdy_mode = 1;
      send_frame(4'hC, 1'b1, -1);
      idle(2);
      check("after_reset_drained", exp_q.size(), 0);

      rdy_mode = 2;
      repeat (40) begin
         w = PKT_W'($urandom_range(0, (1 << PKT_W) - 1));
         if ($urandom_range(0, 4) == 0) begin
            send_frame(w, 1'b0, -1);
            break_hold($urandom_range(0, 3));
         end else begin
            send_frame(w, 1'b1, -1);
         end
         idle($urandom_range(0, 2));
      end

      rdy_mode = 1;
      idle(DEPTH + 3);
      check("drain_empty", exp_q.size(), 0);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter PKT_W, default 4: payload bits per frame.
REQ-002 Parameter FIFO_DEPTH, default 2: output buffer entries, power of two, at least 2.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 io_sIn  input  1  serial line, one bit per clock, idle high.
REQ-006 io_pOut  output  PKT_W  head-of-buffer payload word.
REQ-007 io_validOut  output  1  io_pOut holds a valid word.
REQ-008 io_readyOut  input  1  consumer accepts io_pOut this cycle.
REQ-009 io_frameErr  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 io_overrun  output  1  one-cycle pulse: complete frame dropped because the buffer was full.
REQ-011 io_busy  output  1  high in every state except IDLE.

Function
REQ-012 Frame format SHALL be: start bit 0, then PKT_W data bits LSB first, then stop bit 1. Total length is PKT_W+2 clocks.
REQ-013 The FSM SHALL have states IDLE, DATA, STOP and BREAK.
REQ-014 IDLE: io_sIn==0 SHALL go to DATA with bit counter = 0; io_sIn==1 stays in IDLE.
REQ-015 DATA: each cycle SHALL shift io_sIn into bit position [counter] and increment the counter. On the cycle that captures bit PKT_W-1, the FSM SHALL go to STOP.
REQ-016 Counter width SHALL be clog2(PKT_W+1) bits. The counter SHALL NOT wrap within a frame.
REQ-017 STOP with io_sIn==1: the FSM SHALL push the assembled word into the buffer and go to IDLE.
REQ-018 STOP with io_sIn==0: the FSM SHALL discard the word, pulse io_frameErr for 1 cycle and go to BREAK.
REQ-019 BREAK: the FSM SHALL stay until io_sIn==1, then go to IDLE.
REQ-020 Back-to-back frames (start bit immediately after stop bit) SHALL be received with no lost bit.
REQ-021 Latency: with the buffer empty, io_validOut SHALL rise the cycle after the stop bit is sampled. io_pOut SHALL hold the word from that cycle.
REQ-022 Pop SHALL occur on any cycle where io_validOut && io_readyOut. io_pOut and io_validOut SHALL be stable while io_validOut && !io_readyOut.
REQ-023 Buffer full and push: the word SHALL be dropped, io_overrun pulses 1 cycle, and buffer contents are unchanged.
REQ-024 Buffer full with simultaneous push and pop: the pop SHALL be applied first, the push SHALL be accepted, and io_overrun SHALL stay 0.
REQ-025 Buffer SHALL be first-in first-out. Occupancy counter SHALL span 0..FIFO_DEPTH. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 io_frameErr and io_overrun SHALL be registered outputs. Both may assert in the same cycle as io_validOut.

Reset
REQ-027 reset low SHALL immediately set: FSM = IDLE, counter = 0, shift register = 0, buffer empty, pointers = 0.
REQ-028 reset low SHALL immediately set: io_pOut = 0, io_validOut = 0, io_frameErr = 0, io_overrun = 0, io_busy = 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame. After release, reception SHALL resume at the next start bit seen in IDLE.
REQ-030 Reset deassertion SHALL be synchronised internally to clock: 2-flop, asynchronous assert, synchronous release.

Structure
REQ-031 Shared package deserializer_pkg SHALL hold the FSM state enum, the default PKT_W and FIFO_DEPTH, and the frame-length constant PKT_W+2.
REQ-032 The buffer SHALL be a sub-module deser_fifo with a push/pop/full/empty interface. The FSM and shifter SHALL live in deserializer.

Verification (PKT_W=4, FIFO_DEPTH=2)
REQ-033 io_sIn = 0,0,1,0,1,1 with io_readyOut=1 -> io_pOut=0xA, io_validOut high exactly 1 cycle, on the cycle after the stop bit.
REQ-034 Back-to-back frames 0xA then 0xF (0,0,1,0,1,1,0,1,1,1,1,1) with io_readyOut=1 -> words 0xA and 0xF, 6 cycles apart, no errors.
REQ-035 Frame 0x5 with stop bit 0, then io_sIn held low 3 cycles, then high -> io_frameErr 1-cycle pulse, no io_validOut, io_busy high through BREAK.
REQ-036 io_readyOut=0, frames 0x1, 0x2, 0x3 -> 0x1 and 0x2 buffered, io_overrun pulse after the third stop bit. Then io_readyOut=1 -> 0x1 then 0x2.
REQ-037 Buffer full, io_readyOut=1 on the stop-bit cycle of frame 0x3 -> no overrun, output order 0x1, 0x2, 0x3.
REQ-038 reset low after the 2nd data bit of a frame, released, then frame 0xC -> only 0xC delivered, all outputs 0 during reset.
